// File: rtl/hex_scan_mux.sv
// Four-digit time-multiplexed hex display scanner with frame-synchronous value updates.
// Define LEAD_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always lit).
module hex_scan_mux #(
  parameter int unsigned DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  output logic [3:0]  bi_digit,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] presc_q, presc_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     disp_q, disp_d;
  logic [15:0]     pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  logic            tick;
  logic            frame_end;

  assign tick      = (presc_q == CntMax);
  assign frame_end = tick && (idx_q == 2'd3);

  always_comb begin
    presc_d    = presc_q;
    idx_d      = idx_q;
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;

    if (tick) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end else begin
      presc_d = presc_q + CntW'(1);
    end

    // A load landing on the boundary bypasses pending and goes straight to display.
    if (frame_end) begin
      if (load) begin
        disp_d     = value;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        disp_d     = pend_q;
        pend_vld_d = 1'b0;
      end
    end else if (load) begin
      pend_d     = value;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q    <= '0;
      idx_q      <= '0;
      disp_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  logic [3:0] lit;
  logic [3:0] nibble;

`ifdef LEAD_ZERO_BLANK_EN
  logic [3:0] nib_nz;
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      nib_nz[k] = |disp_q[4*k +: 4];
    end
    lit[0] = 1'b1;
    lit[1] = |nib_nz[3:1];
    lit[2] = |nib_nz[3:2];
    lit[3] = nib_nz[3];
  end
`else
  assign lit = 4'hf;
`endif

  always_comb begin
    unique case (idx_q)
      2'd0: nibble = disp_q[3:0];
      2'd1: nibble = disp_q[7:4];
      2'd2: nibble = disp_q[11:8];
      default: nibble = disp_q[15:12];
    endcase
  end

  always_comb begin
    an       = 4'hf;
    bi_digit = 4'h0;
    if (lit[idx_q]) begin
      an[idx_q] = 1'b0;
      bi_digit  = nibble;
    end
  end

  assign frame_done = frame_end;

endmodule

// File: tb/tb_hex_scan_mux.sv
// Self-checking bench for hex_scan_mux: directed scenarios plus random loads/resets,
// compared each cycle against a cycle-count based reference model.
module tb_hex_scan_mux;

  localparam int unsigned DIV = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load  = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  bi_digit;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Model state: cycles since reset plus the three value holders.
  int          m_t     = 0;
  logic [15:0] m_disp  = 16'h0;
  logic [15:0] m_pend  = 16'h0;
  bit          m_pflag = 1'b0;
  bit          m_valid = 1'b0;

  hex_scan_mux #(.DIV(DIV)) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .value      (value),
    .bi_digit   (bi_digit),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  function automatic int slot();
    return (m_t / DIV) % 4;
  endfunction

  function automatic bit exp_fd();
    return ((m_t % DIV) == DIV - 1) && (slot() == 3);
  endfunction

  function automatic bit digit_shown(input logic [15:0] d, input int k);
`ifdef LEAD_ZERO_BLANK_EN
    return (k == 0) || ((d >> (4 * k)) != 16'h0);
`else
    return (k >= 0);
`endif
  endfunction

  task automatic check();
    int         k;
    logic [3:0] e_an;
    logic [3:0] e_bi;
    logic       e_fd;
    k    = slot();
    e_an = 4'hf;
    e_bi = 4'h0;
    e_fd = exp_fd();
    if (digit_shown(m_disp, k)) begin
      e_an = ~(4'b0001 << k);
      e_bi = 4'((m_disp >> (4 * k)) & 16'hf);
    end
    checks += 3;
    assert (an === e_an) else begin
      errors++;
      $error("FAIL an t=%0d: observed %b expected %b", m_t, an, e_an);
    end
    assert (bi_digit === e_bi) else begin
      errors++;
      $error("FAIL bi_digit t=%0d: observed %h expected %h", m_t, bi_digit, e_bi);
    end
    assert (frame_done === e_fd) else begin
      errors++;
      $error("FAIL frame_done t=%0d: observed %b expected %b", m_t, frame_done, e_fd);
    end
  endtask

  task automatic cycle(input bit r, input bit ld, input logic [15:0] v);
    bit fd;
    reset = r;
    load  = ld;
    value = v;
    @(negedge clock);
    if (m_valid) check();
    @(posedge clock);
    fd = exp_fd();
    if (r) begin
      m_t     = 0;
      m_disp  = 16'h0;
      m_pend  = 16'h0;
      m_pflag = 1'b0;
    end else begin
      if (fd) begin
        if (ld) begin
          m_disp  = v;
          m_pflag = 1'b0;
        end else if (m_pflag) begin
          m_disp  = m_pend;
          m_pflag = 1'b0;
        end
      end else if (ld) begin
        m_pend  = v;
        m_pflag = 1'b1;
      end
      m_t++;
    end
    m_valid = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    logic [15:0] v;
    bit          r;
    bit          ld;

    cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 16'h9999);

    // Free-running scan with nothing loaded.
    idle(36);

    // Mid-frame load, shown from the next frame on.
    idle(6);
    cycle(1'b0, 1'b1, 16'h1A2F);
    idle(40);

    // Two loads in one frame: last one wins.
    for (int i = 0; i < 4 * DIV && slot() != 1; i++) idle(1);
    cycle(1'b0, 1'b1, 16'h1111);
    cycle(1'b0, 1'b1, 16'h2222);
    idle(36);

    // Load exactly on the frame boundary.
    for (int i = 0; i < 4 * DIV && !exp_fd(); i++) idle(1);
    cycle(1'b0, 1'b1, 16'hBEEF);
    idle(36);

    // Reset with a coincident load while scanning digit 2.
    for (int i = 0; i < 4 * DIV && slot() != 2; i++) idle(1);
    cycle(1'b1, 1'b1, 16'h5555);
    idle(36);

    // Leading-zero patterns.
    cycle(1'b0, 1'b1, 16'h0030);
    idle(36);
    cycle(1'b0, 1'b1, 16'h0000);
    idle(36);
    cycle(1'b0, 1'b1, 16'h0400);
    idle(36);

    for (int i = 0; i < 800; i++) begin
      v = 16'($urandom);
      case ($urandom_range(3, 0))
        0: v &= 16'h00ff;
        1: v &= 16'h000f;
        2: v &= 16'h0f0f;
        default: ;
      endcase
      r  = ($urandom_range(99, 0) == 0);
      ld = ($urandom_range(5, 0) == 0);
      cycle(r, ld, v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_scan_mux.md
HEX_SCAN_MUX -- requirements
Module: hex_scan_mux

Interface
REQ-001 SHALL have parameter DIV, default 50000, meaning clock cycles per digit slot (legal range 1..2^20).
REQ-002 SHALL have port clock, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port load, input, 1, one-cycle strobe that offers value for display.
REQ-005 SHALL have port value, input, 16, four hex digits (digit k = value[4k+3:4k], digit 0 least significant).
REQ-006 SHALL have port bi_digit, output, 4, nibble of the digit currently scanned; feeds the downstream 7-segment decoder.
REQ-007 SHALL have port an, output, 4, active-low digit enable (an[k]=0 selects digit k).
REQ-008 SHALL have port frame_done, output, 1, one-cycle pulse at the end of each full 4-digit scan.
REQ-009 Outputs SHALL depend only on registered state, with no combinational path from load or value.

Function
REQ-010 Prescaler SHALL count 0..DIV-1 and wrap, asserting an internal tick in the cycle where count==DIV-1; with DIV=1, tick SHALL be asserted every cycle.
REQ-011 Digit index SHALL advance 0->1->2->3->0 on each tick; outputs for the new index SHALL appear the cycle after the tick.
REQ-012 The frame boundary SHALL be the tick at index 3; frame_done SHALL be high for exactly that cycle.
REQ-013 Load SHALL be accepted in any cycle (no back-pressure); value SHALL be captured into a pending register and the pending flag set.
REQ-014 Repeated loads before a frame boundary SHALL overwrite pending; the last load wins.
REQ-015 At a frame boundary with the pending flag set, the display register SHALL take the pending contents and the pending flag SHALL clear; the displayed value SHALL never change mid-frame.
REQ-016 Load coincident with a frame boundary SHALL commit value directly to the display register and leave the pending flag clear.
REQ-017 bi_digit SHALL equal display nibble [index], and an SHALL be all ones except bit index, which is 0 (subject to REQ-024).
REQ-018 Display digits with no load since reset SHALL show 0.

Reset
REQ-019 Reset SHALL take priority over load and tick in the same cycle.
REQ-020 Reset SHALL clear prescaler, index, display register, pending register and pending flag to 0.
REQ-021 During and after reset: an=4'b1110, bi_digit=4'h0, frame_done=0.
REQ-022 Reset mid-frame SHALL discard any pending value; the next frame SHALL start at index 0 with a full DIV-cycle slot.

Configuration
REQ-023 Macro LEAD_ZERO_BLANK_EN SHALL select leading-zero suppression.
REQ-024 With LEAD_ZERO_BLANK_EN defined, digit k (k>=1) SHALL be blanked (an=4'b1111 during its slot, bi_digit=4'h0) when display nibbles k..3 are all zero; digit 0 SHALL never be blanked, and slot timing SHALL be unchanged.
REQ-025 Without LEAD_ZERO_BLANK_EN, all four digits SHALL always be enabled in turn.

Verification
REQ-026 DIV=4, reset released, no load -> an cycles 1110,1101,1011,0111 with 4 cycles each; bi_digit=0; frame_done pulses every 16 cycles.
REQ-027 DIV=4, load value=16'h1A2F mid-frame -> display unchanged until the frame_done cycle; the next frame shows F,2,A,1 on an 1110,1101,1011,0111.
REQ-028 Loads 16'h1111 then 16'h2222 in the same frame -> the next frame shows 2,2,2,2; 16'h1111 is never displayed.
REQ-029 Load 16'hBEEF on the frame_done cycle -> the following frame shows F,E,E,B and the pending flag is clear.
REQ-030 Reset asserted on a cycle with load=1 while index=2 -> an=1110, bi_digit=0, loaded value discarded.
REQ-031 LEAD_ZERO_BLANK_EN defined, value 16'h0030 -> an=1110 (0), 1101 (3), then 1111 in slots 2 and 3; value 16'h0000 -> only digit 0 is lit, showing 0.
